// File: rtl/nbit_add_sub_unsigned.sv
`default_nettype none
// ============================================================================
// Module      : nbit_add_sub_unsigned
// Description : Registered N-bit unsigned adder/subtractor. Computes A+B when
//               k=0 or A-B when k=1 through a ripple-carry chain. The (N+1)-bit
//               result carries the carry (add) or borrow (subtract) in its MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module nbit_add_sub_unsigned #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         k,
    output logic [N:0]   S
);

    // B is conditionally inverted and k feeds the carry-in, so subtraction
    // becomes A + ~B + 1 on the same chain.
    logic [N-1:0] w_b_x;
    logic [N-1:0] w_sum;
    logic [N:0]   w_carry;
    logic [N:0]   S_d;
    logic [N:0]   S_q;

    assign w_carry[0] = k;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            assign w_b_x[gi]      = B[gi] ^ k;
            assign w_sum[gi]      = A[gi] ^ w_b_x[gi] ^ w_carry[gi];
            assign w_carry[gi+1]  = (A[gi] & w_b_x[gi])
                                  | (A[gi] & w_carry[gi])
                                  | (w_b_x[gi] & w_carry[gi]);
        end
    endgenerate

    // For subtraction the chain's carry-out is set when no borrow occurred,
    // so inverting it with k yields the borrow (1 iff A < B). That also makes
    // the full (N+1)-bit word the two's-complement difference.
    assign S_d = {w_carry[N] ^ k, w_sum};

    // Result register: asynchronously cleared, captures a new result every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q <= '0;
        end else begin
            S_q <= S_d;
        end
    end

    assign S = S_q;

endmodule
`default_nettype wire

// File: tb/tb_nbit_add_sub_unsigned.sv
`default_nettype none
// ============================================================================
// Module      : tb_nbit_add_sub_unsigned
// Description : Self-checking bench for nbit_add_sub_unsigned at N = 1, 8, 64.
//               All three instances share clock, reset and the operation
//               select; narrower instances take the low bits of the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nbit_add_sub_unsigned;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] A64 = '0;
    logic [63:0] B64 = '0;
    logic        k = 1'b0;

    logic [1:0]  S1;
    logic [8:0]  S8;
    logic [64:0] S64;

    always #5 clk = ~clk;

    nbit_add_sub_unsigned #(.N(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .A(A64[0]), .B(B64[0]), .k(k), .S(S1)
    );
    nbit_add_sub_unsigned #(.N(8)) u_n8 (
        .clk(clk), .rst_n(rst_n), .A(A64[7:0]), .B(B64[7:0]), .k(k), .S(S8)
    );
    nbit_add_sub_unsigned #(.N(64)) u_n64 (
        .clk(clk), .rst_n(rst_n), .A(A64), .B(B64), .k(k), .S(S64)
    );

    // Reference model: plain arithmetic on zero-extended operands.
    logic [1:0]  exp1;
    logic [8:0]  exp8;
    logic [64:0] exp64;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp1  <= '0;
            exp8  <= '0;
            exp64 <= '0;
        end else if (k) begin
            exp1  <= {1'b0, A64[0]}   - {1'b0, B64[0]};
            exp8  <= {1'b0, A64[7:0]} - {1'b0, B64[7:0]};
            exp64 <= {1'b0, A64}      - {1'b0, B64};
        end else begin
            exp1  <= {1'b0, A64[0]}   + {1'b0, B64[0]};
            exp8  <= {1'b0, A64[7:0]} + {1'b0, B64[7:0]};
            exp64 <= {1'b0, A64}      + {1'b0, B64};
        end
    end

    // Literal expectation handed from the stimulus to the compare process.
    int          lit_id = 0;
    int          lit_sel = 0;
    logic [64:0] lit_exp = '0;
    string       lit_name = "";

    int          n_checks = 0;
    int          n_fail = 0;
    bit          chk_on = 1'b0;

    // Single compare process: every negedge check DUT against the model,
    // and any pending literal against both DUT and model.
    initial begin : p_compare
        int          seen_id;
        logic [64:0] dut_v;
        logic [64:0] mdl_v;
        seen_id = 0;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                n_checks++;
                if (S1 !== exp1) begin
                    n_fail++;
                    $display("FAIL model_n1 t=%0t S=%h expected=%h", $time, S1, exp1);
                end
                n_checks++;
                if (S8 !== exp8) begin
                    n_fail++;
                    $display("FAIL model_n8 t=%0t S=%h expected=%h", $time, S8, exp8);
                end
                n_checks++;
                if (S64 !== exp64) begin
                    n_fail++;
                    $display("FAIL model_n64 t=%0t S=%h expected=%h", $time, S64, exp64);
                end
            end
            if (lit_id != seen_id) begin
                seen_id = lit_id;
                case (lit_sel)
                    0:       begin dut_v = {63'b0, S1}; mdl_v = {63'b0, exp1}; end
                    1:       begin dut_v = {56'b0, S8}; mdl_v = {56'b0, exp8}; end
                    default: begin dut_v = S64;         mdl_v = exp64;         end
                endcase
                n_checks++;
                if (dut_v !== lit_exp) begin
                    n_fail++;
                    $display("FAIL %s dut S=%h expected=%h", lit_name, dut_v, lit_exp);
                end
                n_checks++;
                if (mdl_v !== lit_exp) begin
                    n_fail++;
                    $display("FAIL %s_model got=%h expected=%h", lit_name, mdl_v, lit_exp);
                end
            end
        end
    end

    // Post a literal expectation; the compare process evaluates it at the next negedge.
    task automatic expect_lit(input int sel, input logic [64:0] e, input string name);
        lit_sel  = sel;
        lit_exp  = e;
        lit_name = name;
        lit_id   = lit_id + 1;
        @(negedge clk);
        #1;
    endtask

    // Apply operands just after an edge, then let the next edge capture them.
    task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic kk);
        @(posedge clk);
        #1;
        A64 = a;
        B64 = b;
        k   = kk;
        @(posedge clk);
        #1;
    endtask

    initial begin : p_stim
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        expect_lit(1, 65'h0, "reset_n8");
        expect_lit(2, 65'h0, "reset_n64");
        rst_n = 1'b1;

        apply(64'd200, 64'd100, 1'b0); expect_lit(1, 65'h12C, "add_200_100");
        apply(64'd100, 64'd200, 1'b1); expect_lit(1, 65'h19C, "sub_100_200");
        apply(64'd255, 64'd255, 1'b0); expect_lit(1, 65'h1FE, "add_max_max");
        apply(64'd50,  64'd50,  1'b1); expect_lit(1, 65'h0,   "sub_equal");
        apply(64'd0,   64'd255, 1'b1); expect_lit(1, 65'h101, "sub_0_max");
        apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        expect_lit(2, 65'h1_0000_0000_0000_0000, "add64_wrap");
        apply(64'd0, 64'd1, 1'b1);
        expect_lit(2, 65'h1_FFFF_FFFF_FFFF_FFFF, "sub64_neg1");
        expect_lit(0, 65'h3, "sub1_0_1");
        apply(64'd1, 64'd1, 1'b0);     expect_lit(0, 65'h2, "add1_1_1");

        // Asynchronous reset between edges clears S immediately.
        apply(64'd200, 64'd100, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        expect_lit(1, 65'h0, "async_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_lit(1, 65'h12C, "after_reset");

        // Back-to-back random operations with k toggling freely.
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            A64 = {$urandom, $urandom};
            B64 = (i % 7 == 0) ? A64 : {$urandom, $urandom};
            k   = $urandom_range(0, 1) == 1;
        end
        repeat (2) @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
